prod_window_acc: RTL and testbench
==================================

// Module: prod_window_acc
// PURPOSE
//  Downstream consumer of the last-two-values multiplier stage: takes its 2*W-bit product stream,
//  accumulates N accepted products per window, reports window sum and window maximum.
//  Valid/ready on both sides; result held until the consumer takes it.
//  Sits between the multiplier and the statistics/report logic.
// PARAMETERS
//  W      4   operand width of upstream multiplier; product width PW = 2*W
//  N      4   products per window, N >= 1
//  ACC_W  2*W+$clog2(N) (min 2*W)   sum width; exact, cannot overflow for N samples of (2^PW-1)
// PORTS
//  clk      in   1      clock, all state updates on rising edge
//  rst_b    in   1      reset, synchronous, active-low
//  clr      in   1      synchronous window abort, active-high
//  in_prod  in   2*W    product from multiplier stage
//  in_vld   in   1      in_prod valid this cycle
//  in_rdy   out  1      block can accept a product this cycle
//  sum      out  ACC_W  window sum, stable while out_vld=1
//  max      out  2*W    largest product in window, stable while out_vld=1
//  cnt      out  clog2(N+1)  products accepted in current window
//  out_vld  out  1      sum/max valid
//  out_rdy  in   1      consumer takes result when out_vld & out_rdy
// BEHAVIOUR
//  Reset (rst_b=0 at edge): state=IDLE, acc=0, cnt=0, sum=0, max=0, out_vld=0. in_rdy=0 while rst_b=0.
//  Priority per edge: rst_b > clr > handshakes.
//  States: IDLE (cnt=0), ACC (0<cnt<N), HOLD (result presented). in_rdy = rst_b & (state!=HOLD), combinational.
//  Accept = in_vld & in_rdy. Not accepted -> no state change (in_prod ignored).
//  IDLE/ACC accept, cnt+1<N: acc+=in_prod (zero-extended), run_max=max(run_max,in_prod), cnt++, state=ACC.
//  Accept of Nth product: sum<=acc+in_prod, max<=max(run_max,in_prod), out_vld<=1 at that same edge,
//   acc/run_max/cnt<=0, state=HOLD. Latency: result visible 1 cycle after Nth accept edge.
//  N=1: every accept goes IDLE->HOLD directly; sum=max=in_prod.
//  HOLD: in_rdy=0, sum/max/out_vld frozen until out_vld&out_rdy edge -> out_vld<=0, state=IDLE.
//   in_rdy rises the cycle after the take (no same-cycle take+accept).
//  out_rdy held 1 while out_vld=0: no effect. out_vld never drops without a take, clr or reset.
//  clr=1: acc, run_max, cnt <=0, out_vld<=0, state=IDLE; a pending result is discarded; in_vld ignored
//   that cycle. sum/max registers keep last values (don't-care while out_vld=0).
//  Reset mid-window or in HOLD: same as power-on reset; partial window lost.
//  Products of 0 are counted and summed normally (ignore filtering lives upstream).
//  All arithmetic unsigned; comparisons unsigned; no saturation needed (ACC_W exact).
// STRUCTURE
//  Shared header prod_acc_defs.vh: state encodings IDLE=2'd0, ACC=2'd1, HOLD=2'd2; clog2 helper function.
//  Sub-module mod_n_counter (#(N)): sync clear, enable, count output, terminal flag at N-1 ->
//   drives cnt and the Nth-sample detect. Remaining datapath (adder, max compare, result regs) inline.
// TESTING  (default W=4, N=4, ACC_W=10; out_rdy=1 unless stated)
//  1 Reset: rst_b=0 two edges -> out_vld=0, sum=0, max=0, cnt=0, in_rdy=0; release -> in_rdy=1.
//  2 Window: products 50,25,10,65 back-to-back -> one cycle after 4th accept out_vld=1, sum=150,
//    max=65; cnt=0; next cycle out_vld=0, in_rdy=1.
//  3 Backpressure/bubbles: 169,195,225,225 with in_vld gaps, out_rdy=0 for 5 cycles -> sum=814, max=225
//    held stable, in_rdy=0 throughout hold, extra in_vld ignored; out_rdy=1 -> taken, IDLE.
//  4 Overflow bound: four 225s then (W=4) check sum=900 exact; W=6 N=4 four 3969s -> sum=15876, ACC_W=14.
//  5 clr mid-window: 10,20 then clr=1 with in_vld=1 -> cnt=0; then 1,2,3,4 -> sum=10, max=4.
//    clr during HOLD -> out_vld=0 next edge, result lost.
//  6 N=1 and reset in HOLD: N=1, product 7 -> out_vld=1 sum=7 max=7; rst_b=0 while held -> out_vld=0.

Source files
------------

// File: rtl/prod_window_acc_pkg.sv
// Shared definitions for the product window accumulator: state encodings and width helpers.
package prod_window_acc_pkg;

    // Window FSM encodings (fixed values, shared with legacy consumers)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Ceiling log2, usable in parameter expressions; clog2(1) = 0
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/prod_window_acc_mod_n_counter.sv
// Modulo-N sample counter: counts enabled events 0..N-1 and wraps, flags the last slot.
module mod_n_counter
    import prod_window_acc_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          term
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Terminal flag marks the slot that completes the window
    always_comb begin
        term = (count_q == CW'(N - 1));
    end

    // Next count: clear wins, then wrap at the terminal slot, else increment
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            if (term) begin
                count_d = '0;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/prod_window_acc.sv
// Product window accumulator: sums N accepted products and tracks their maximum, then holds
// the result until the downstream consumer takes it.
module prod_window_acc
    import prod_window_acc_pkg::*;
#(
    parameter int unsigned W     = 4,
    parameter int unsigned N     = 4,
    parameter int unsigned ACC_W = 2 * W + clog2(N),
    localparam int unsigned PW   = 2 * W,
    localparam int unsigned CW   = clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             clr,
    input  logic [PW-1:0]    in_prod,
    input  logic             in_vld,
    output logic             in_rdy,
    output logic [ACC_W-1:0] sum,
    output logic [PW-1:0]    max,
    output logic [CW-1:0]    cnt,
    output logic             out_vld,
    input  logic             out_rdy
);

    logic [1:0]       state_q,   state_d;
    logic [ACC_W-1:0] acc_q,     acc_d;
    logic [PW-1:0]    run_max_q, run_max_d;
    logic [ACC_W-1:0] sum_q,     sum_d;
    logic [PW-1:0]    max_q,     max_d;
    logic             out_vld_q, out_vld_d;

    logic             accept;
    logic             take;
    logic             last_slot;
    logic [ACC_W-1:0] acc_plus;
    logic [PW-1:0]    max_new;

    // Handshake qualifiers; no input is taken while a result is pending or in reset
    always_comb begin
        in_rdy = rst_b & (state_q != ST_HOLD);
        accept = in_vld & in_rdy;
        take   = out_vld_q & out_rdy;
    end

    // Sample counter drives cnt and detects the product that closes the window
    mod_n_counter #(
        .N  (N),
        .CW (CW)
    ) u_cnt (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (clr),
        .en    (accept),
        .count (cnt),
        .term  (last_slot)
    );

    // Running sum and maximum including the product being offered this cycle
    always_comb begin
        acc_plus = acc_q + ACC_W'(in_prod);
        max_new  = (in_prod > run_max_q) ? in_prod : run_max_q;
    end

    // Window sequencing: clr aborts everything, otherwise accumulate, publish, wait for take
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        run_max_d = run_max_q;
        sum_d     = sum_q;
        max_d     = max_q;
        out_vld_d = out_vld_q;
        if (clr) begin
            // sum/max keep their old contents; they are ignored while out_vld is low
            state_d   = ST_IDLE;
            acc_d     = '0;
            run_max_d = '0;
            out_vld_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACC: begin
                    if (accept) begin
                        if (last_slot) begin
                            sum_d     = acc_plus;
                            max_d     = max_new;
                            out_vld_d = 1'b1;
                            acc_d     = '0;
                            run_max_d = '0;
                            state_d   = ST_HOLD;
                        end else begin
                            acc_d     = acc_plus;
                            run_max_d = max_new;
                            state_d   = ST_ACC;
                        end
                    end
                end
                ST_HOLD: begin
                    if (take) begin
                        out_vld_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    acc_d     = '0;
                    run_max_d = '0;
                    out_vld_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            run_max_q <= '0;
            sum_q     <= '0;
            max_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            run_max_q <= run_max_d;
            sum_q     <= sum_d;
            max_q     <= max_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign sum     = sum_q;
    assign max     = max_q;
    assign out_vld = out_vld_q;

endmodule

// File: tb/tb_prod_window_acc.sv
// Bench for prod_window_acc: directed windows, hold/backpressure, clr and reset cases, then
// randomized traffic against a queue-based window model.
module tb_prod_window_acc;

    localparam int unsigned N = 4;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance: W=4, N=4, ACC_W=10
    logic       rst_b, clr, in_vld, in_rdy, out_vld, out_rdy;
    logic [7:0] in_prod, max;
    logic [9:0] sum;
    logic [2:0] cnt;

    prod_window_acc #(.W(4), .N(N)) u_dut (
        .clk(clk), .rst_b(rst_b), .clr(clr), .in_prod(in_prod), .in_vld(in_vld),
        .in_rdy(in_rdy), .sum(sum), .max(max), .cnt(cnt), .out_vld(out_vld), .out_rdy(out_rdy)
    );

    // Wide instance: W=6, N=4, ACC_W=14
    logic        rst_b1, clr1, in_vld1, in_rdy1, out_vld1, out_rdy1;
    logic [11:0] in_prod1, max1;
    logic [13:0] sum1;
    logic [2:0]  cnt1;

    prod_window_acc #(.W(6), .N(4)) u_dut_w6 (
        .clk(clk), .rst_b(rst_b1), .clr(clr1), .in_prod(in_prod1), .in_vld(in_vld1),
        .in_rdy(in_rdy1), .sum(sum1), .max(max1), .cnt(cnt1), .out_vld(out_vld1),
        .out_rdy(out_rdy1)
    );

    // Single-sample instance: W=4, N=1, ACC_W=8
    logic       rst_b2, clr2, in_vld2, in_rdy2, out_vld2, out_rdy2;
    logic [7:0] in_prod2, max2;
    logic [7:0] sum2;
    logic [0:0] cnt2;

    prod_window_acc #(.W(4), .N(1)) u_dut_n1 (
        .clk(clk), .rst_b(rst_b2), .clr(clr2), .in_prod(in_prod2), .in_vld(in_vld2),
        .in_rdy(in_rdy2), .sum(sum2), .max(max2), .cnt(cnt2), .out_vld(out_vld2),
        .out_rdy(out_rdy2)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model: products of the open window, plus the published result
    int unsigned win[$];
    bit          hold   = 1'b0;
    logic [63:0] m_sum  = '0;
    logic [63:0] m_max  = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock on the default instance: drive, advance the model, compare all outputs
    task automatic step(input bit r, input bit c, input bit v, input int unsigned p,
                        input bit ordy);
        logic [63:0] s, mx;
        rst_b   = r;
        clr     = c;
        in_vld  = v;
        in_prod = p[7:0];
        out_rdy = ordy;
        @(posedge clk);
        if (!r) begin
            win.delete();
            hold  = 1'b0;
            m_sum = '0;
            m_max = '0;
        end else if (c) begin
            win.delete();
            hold = 1'b0;
        end else if (hold) begin
            if (ordy) hold = 1'b0;
        end else if (v) begin
            win.push_back(p);
            if (win.size() == N) begin
                s  = '0;
                mx = '0;
                foreach (win[i]) begin
                    s = s + 64'(win[i]);
                    if (64'(win[i]) > mx) mx = 64'(win[i]);
                end
                m_sum = s;
                m_max = mx;
                hold  = 1'b1;
                win.delete();
            end
        end
        #1;
        check("out_vld", 64'(out_vld), 64'(hold));
        check("cnt", 64'(cnt), 64'(win.size()));
        check("in_rdy", 64'(in_rdy), 64'(r && !hold));
        check("sum", 64'(sum), m_sum);
        check("max", 64'(max), m_max);
    endtask

    initial begin
        rst_b = 1'b0; clr = 1'b0; in_vld = 1'b0; in_prod = '0; out_rdy = 1'b1;
        rst_b1 = 1'b0; clr1 = 1'b0; in_vld1 = 1'b0; in_prod1 = '0; out_rdy1 = 1'b0;
        rst_b2 = 1'b0; clr2 = 1'b0; in_vld2 = 1'b0; in_prod2 = '0; out_rdy2 = 1'b0;

        // Reset held two edges, then released
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 33, 1);
        check("rst_out_vld", 64'(out_vld), 64'd0);
        check("rst_in_rdy", 64'(in_rdy), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        step(1, 0, 0, 0, 1);
        check("rel_in_rdy", 64'(in_rdy), 64'd1);

        // Back-to-back window
        step(1, 0, 1, 50, 1);
        step(1, 0, 1, 25, 1);
        step(1, 0, 1, 10, 1);
        step(1, 0, 1, 65, 1);
        check("win_vld", 64'(out_vld), 64'd1);
        check("win_sum", 64'(sum), 64'd150);
        check("win_max", 64'(max), 64'd65);
        check("win_cnt", 64'(cnt), 64'd0);
        step(1, 0, 0, 0, 1);
        check("win_taken", 64'(out_vld), 64'd0);
        check("win_rdy", 64'(in_rdy), 64'd1);

        // Bubbles on input, consumer stalled for five cycles with extra in_vld offered
        step(1, 0, 1, 169, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 195, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 225, 0);
        step(1, 0, 1, 225, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, 99, 0);
            check("bp_sum", 64'(sum), 64'd814);
            check("bp_max", 64'(max), 64'd225);
            check("bp_rdy", 64'(in_rdy), 64'd0);
            check("bp_vld", 64'(out_vld), 64'd1);
        end
        step(1, 0, 0, 0, 1);
        check("bp_taken", 64'(out_vld), 64'd0);
        check("bp_cnt", 64'(cnt), 64'd0);

        // Largest products: exact sum
        for (int i = 0; i < 4; i++) step(1, 0, 1, 225, 1);
        check("ovf_sum", 64'(sum), 64'd900);
        step(1, 0, 0, 0, 1);

        // Abort mid-window with in_vld high, then a fresh window
        step(1, 0, 1, 10, 1);
        step(1, 0, 1, 20, 1);
        step(1, 1, 1, 99, 1);
        check("clr_cnt", 64'(cnt), 64'd0);
        step(1, 0, 1, 1, 1);
        step(1, 0, 1, 2, 1);
        step(1, 0, 1, 3, 1);
        step(1, 0, 1, 4, 1);
        check("clr_sum", 64'(sum), 64'd10);
        check("clr_max", 64'(max), 64'd4);
        // Abort while holding: result dropped
        step(1, 1, 0, 0, 0);
        check("clr_hold_vld", 64'(out_vld), 64'd0);
        check("clr_hold_rdy", 64'(in_rdy), 64'd1);

        // Wide instance: four maximal 12-bit products
        @(posedge clk); #1;
        rst_b1 = 1'b1; in_vld1 = 1'b1; in_prod1 = 12'd3969;
        repeat (4) @(posedge clk);
        #1;
        in_vld1 = 1'b0;
        check("w6_vld", 64'(out_vld1), 64'd1);
        check("w6_sum", 64'(sum1), 64'd15876);
        check("w6_max", 64'(max1), 64'd3969);

        // N=1: single product completes the window; reset while held drops it
        rst_b2 = 1'b1; in_vld2 = 1'b1; in_prod2 = 8'd7;
        @(posedge clk); #1;
        in_vld2 = 1'b0;
        check("n1_vld", 64'(out_vld2), 64'd1);
        check("n1_sum", 64'(sum2), 64'd7);
        check("n1_max", 64'(max2), 64'd7);
        check("n1_cnt", 64'(cnt2), 64'd0);
        check("n1_rdy", 64'(in_rdy2), 64'd0);
        rst_b2 = 1'b0;
        @(posedge clk); #1;
        check("n1_rst_vld", 64'(out_vld2), 64'd0);
        check("n1_rst_sum", 64'(sum2), 64'd0);

        // Randomized traffic, including zero products, clr and occasional reset
        for (int i = 0; i < 400; i++) begin
            int unsigned a, b;
            a = $urandom_range(0, 15);
            b = $urandom_range(0, 15);
            step($urandom_range(0, 99) != 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) < 7, a * b, $urandom_range(0, 9) < 6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
